// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - pipeline/CSR-facing signal bundle for the trap/return sequencer
interface trap_ctrl_if;
    // pipeline and memory side
    logic        MMU_WAIT;
    logic        EXC_EN;
    logic [31:0] EXC_CODE;
    logic [31:0] EXC_PC;
    logic        MRET_EN;
    logic [31:0] MRET_EPC;
    logic        INT_EXT;
    logic        INT_SOFT;
    logic        INT_TIMER;
    logic [31:0] INT_PC;
    // CSR file side
    logic        INT_ALLOW;
    logic [1:0]  TRAP_VEC_MODE;
    logic [31:0] TRAP_VEC_BASE;
    logic        TRAP_EN;
    logic [31:0] TRAP_CODE;
    logic [31:0] TRAP_PC;
    logic        MRET_COMMIT;
    // fetch side
    logic        FLUSH;
    logic        JMP_DO;
    logic [31:0] JMP_PC;
    logic        BUSY;

    // the sequencer is the initiator of trap commits and redirects
    modport master (
        input  MMU_WAIT, EXC_EN, EXC_CODE, EXC_PC, MRET_EN, MRET_EPC,
        input  INT_EXT, INT_SOFT, INT_TIMER, INT_PC,
        input  INT_ALLOW, TRAP_VEC_MODE, TRAP_VEC_BASE,
        output TRAP_EN, TRAP_CODE, TRAP_PC, MRET_COMMIT,
        output FLUSH, JMP_DO, JMP_PC, BUSY
    );

    modport slave (
        output MMU_WAIT, EXC_EN, EXC_CODE, EXC_PC, MRET_EN, MRET_EPC,
        output INT_EXT, INT_SOFT, INT_TIMER, INT_PC,
        output INT_ALLOW, TRAP_VEC_MODE, TRAP_VEC_BASE,
        input  TRAP_EN, TRAP_CODE, TRAP_PC, MRET_COMMIT,
        input  FLUSH, JMP_DO, JMP_PC, BUSY
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/mret sequencer (IDLE/WAIT/COMMIT/JUMP), optional vectoring via TRAP_CTRL_VECTORED_EN
module trap_ctrl (
    input  logic        CLK,
    input  logic        RST,
    trap_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2,
        S_JUMP   = 2'd3
    } state_t;

    localparam logic [31:0] CODE_INT_EXT   = 32'h8000_000B;
    localparam logic [31:0] CODE_INT_SOFT  = 32'h8000_0003;
    localparam logic [31:0] CODE_INT_TIMER = 32'h8000_0007;

    state_t      r_state;
    state_t      w_state_next;

    // latched winning event
    logic        r_is_mret;
    logic [31:0] r_code;
    logic [31:0] r_pc;

    // arbitration result for the current cycle
    logic        w_req_valid;
    logic        w_req_mret;
    logic [31:0] w_req_code;
    logic [31:0] w_req_pc;

    // event that will be committed: freshly arbitrated in IDLE, latched otherwise
    logic        w_ev_mret;
    logic [31:0] w_ev_code;
    logic [31:0] w_ev_pc;

    logic [31:0] w_target;

    // registered outputs and their next values
    logic        r_trap_en,     w_trap_en_d;
    logic        r_mret_commit, w_mret_commit_d;
    logic        r_flush,       w_flush_d;
    logic        r_jmp_do,      w_jmp_do_d;
    logic        r_busy,        w_busy_d;
    logic [31:0] r_trap_code,   w_trap_code_d;
    logic [31:0] r_trap_pc,     w_trap_pc_d;
    logic [31:0] r_jmp_pc,      w_jmp_pc_d;

    // fixed-priority arbitration: exception, mret, then enabled interrupts ext/soft/timer
    always_comb begin
        w_req_valid = 1'b0;
        w_req_mret  = 1'b0;
        w_req_code  = 32'h0;
        w_req_pc    = 32'h0;
        if (bus.EXC_EN) begin
            w_req_valid = 1'b1;
            w_req_code  = bus.EXC_CODE;
            w_req_pc    = bus.EXC_PC;
        end else if (bus.MRET_EN) begin
            w_req_valid = 1'b1;
            w_req_mret  = 1'b1;
            w_req_pc    = bus.MRET_EPC;
        end else if (bus.INT_ALLOW && bus.INT_EXT) begin
            w_req_valid = 1'b1;
            w_req_code  = CODE_INT_EXT;
            w_req_pc    = bus.INT_PC;
        end else if (bus.INT_ALLOW && bus.INT_SOFT) begin
            w_req_valid = 1'b1;
            w_req_code  = CODE_INT_SOFT;
            w_req_pc    = bus.INT_PC;
        end else if (bus.INT_ALLOW && bus.INT_TIMER) begin
            w_req_valid = 1'b1;
            w_req_code  = CODE_INT_TIMER;
            w_req_pc    = bus.INT_PC;
        end
    end

    // select the event being sequenced so outputs can be registered on the latch edge
    always_comb begin
        if (r_state == S_IDLE) begin
            w_ev_mret = w_req_mret;
            w_ev_code = w_req_code;
            w_ev_pc   = w_req_pc;
        end else begin
            w_ev_mret = r_is_mret;
            w_ev_code = r_code;
            w_ev_pc   = r_pc;
        end
    end

    // latch the winner only in IDLE; requests in other states belong to flushed work
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_is_mret <= 1'b0;
            r_code    <= 32'h0;
            r_pc      <= 32'h0;
        end else if (r_state == S_IDLE && w_req_valid) begin
            r_is_mret <= w_req_mret;
            r_code    <= w_req_code;
            r_pc      <= w_req_pc;
        end
    end

    // redirect target, evaluated from the live CSR values while in COMMIT
`ifdef TRAP_CTRL_VECTORED_EN
    always_comb begin
        if (r_is_mret) begin
            w_target = bus.MRET_EPC;
        end else if (bus.TRAP_VEC_MODE == 2'd1 && r_code[31]) begin
            // code[30:0] << 2 truncated to 32 bits keeps only code[29:0]
            w_target = bus.TRAP_VEC_BASE + {r_code[29:0], 2'b00};
        end else begin
            w_target = bus.TRAP_VEC_BASE;
        end
    end
`else
    // direct mode only: the vector mode field has no effect
    logic w_unused_mode;
    assign w_unused_mode = ^bus.TRAP_VEC_MODE;

    always_comb begin
        if (r_is_mret) begin
            w_target = bus.MRET_EPC;
        end else begin
            w_target = bus.TRAP_VEC_BASE;
        end
    end
`endif

    // state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_valid) begin
                    w_state_next = bus.MMU_WAIT ? S_WAIT : S_COMMIT;
                end
            end
            S_WAIT: begin
                if (!bus.MMU_WAIT) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: w_state_next = S_JUMP;
            S_JUMP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // output values for the state being entered, so every output is a flop
    always_comb begin
        w_trap_en_d     = 1'b0;
        w_mret_commit_d = 1'b0;
        w_flush_d       = 1'b0;
        w_jmp_do_d      = 1'b0;
        w_busy_d        = (w_state_next != S_IDLE);
        w_trap_code_d   = r_trap_code;
        w_trap_pc_d     = r_trap_pc;
        w_jmp_pc_d      = r_jmp_pc;
        case (w_state_next)
            S_COMMIT: begin
                w_flush_d = 1'b1;
                if (w_ev_mret) begin
                    w_mret_commit_d = 1'b1;
                end else begin
                    w_trap_en_d   = 1'b1;
                    w_trap_code_d = w_ev_code;
                    w_trap_pc_d   = w_ev_pc;
                end
            end
            S_JUMP: begin
                w_flush_d  = 1'b1;
                w_jmp_do_d = 1'b1;
                w_jmp_pc_d = w_target;
            end
            default: begin
                w_flush_d = 1'b0;
            end
        endcase
    end

    // output registers; async reset aborts any sequence with all strobes low
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_trap_en     <= 1'b0;
            r_mret_commit <= 1'b0;
            r_flush       <= 1'b0;
            r_jmp_do      <= 1'b0;
            r_busy        <= 1'b0;
            r_trap_code   <= 32'h0;
            r_trap_pc     <= 32'h0;
            r_jmp_pc      <= 32'h0;
        end else begin
            r_trap_en     <= w_trap_en_d;
            r_mret_commit <= w_mret_commit_d;
            r_flush       <= w_flush_d;
            r_jmp_do      <= w_jmp_do_d;
            r_busy        <= w_busy_d;
            r_trap_code   <= w_trap_code_d;
            r_trap_pc     <= w_trap_pc_d;
            r_jmp_pc      <= w_jmp_pc_d;
        end
    end

    assign bus.TRAP_EN     = r_trap_en;
    assign bus.TRAP_CODE   = r_trap_code;
    assign bus.TRAP_PC     = r_trap_pc;
    assign bus.MRET_COMMIT = r_mret_commit;
    assign bus.FLUSH       = r_flush;
    assign bus.JMP_DO      = r_jmp_do;
    assign bus.JMP_PC      = r_jmp_pc;
    assign bus.BUSY        = r_busy;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    trap_ctrl_if bus_if ();

    trap_ctrl dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

`ifdef TRAP_CTRL_VECTORED_EN
    localparam logic [31:0] EXP_TIMER_VEC = 32'h0000_101C;
    localparam logic [31:0] EXP_EXT_VEC   = 32'h0000_202C;
`else
    localparam logic [31:0] EXP_TIMER_VEC = 32'h0000_1000;
    localparam logic [31:0] EXP_EXT_VEC   = 32'h0000_2000;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance one cycle and land on the falling edge for sampling/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        bus_if.EXC_EN    = 1'b0;
        bus_if.MRET_EN   = 1'b0;
        bus_if.INT_EXT   = 1'b0;
        bus_if.INT_SOFT  = 1'b0;
        bus_if.INT_TIMER = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"},  {31'b0, bus_if.BUSY},    32'd0);
        check_val({tag, "_flush"}, {31'b0, bus_if.FLUSH},   32'd0);
        check_val({tag, "_trap"},  {31'b0, bus_if.TRAP_EN}, 32'd0);
        check_val({tag, "_jmp"},   {31'b0, bus_if.JMP_DO},  32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        clear_reqs();
        bus_if.MMU_WAIT      = 1'b0;
        bus_if.EXC_CODE      = 32'h0;
        bus_if.EXC_PC        = 32'h0;
        bus_if.MRET_EPC      = 32'h0;
        bus_if.INT_PC        = 32'h0;
        bus_if.INT_ALLOW     = 1'b0;
        bus_if.TRAP_VEC_MODE = 2'd0;
        bus_if.TRAP_VEC_BASE = 32'h800;

        // reset state
        step();
        step();
        check_idle("rst");
        check_val("rst_mret",  {31'b0, bus_if.MRET_COMMIT}, 32'd0);
        check_val("rst_code",  bus_if.TRAP_CODE, 32'h0);
        check_val("rst_pc",    bus_if.TRAP_PC,   32'h0);
        check_val("rst_jmppc", bus_if.JMP_PC,    32'h0);
        rst_n = 1'b1;
        step();

        // exception, no stall
        bus_if.EXC_EN   = 1'b1;
        bus_if.EXC_CODE = 32'd2;
        bus_if.EXC_PC   = 32'h100;
        step();
        clear_reqs();
        check_val("exc_trap_en", {31'b0, bus_if.TRAP_EN}, 32'd1);
        check_val("exc_code",    bus_if.TRAP_CODE, 32'd2);
        check_val("exc_pc",      bus_if.TRAP_PC,   32'h100);
        check_val("exc_flush1",  {31'b0, bus_if.FLUSH},  32'd1);
        check_val("exc_jmp0",    {31'b0, bus_if.JMP_DO}, 32'd0);
        step();
        check_val("exc_jmp_do",  {31'b0, bus_if.JMP_DO},  32'd1);
        check_val("exc_jmp_pc",  bus_if.JMP_PC, 32'h800);
        check_val("exc_flush2",  {31'b0, bus_if.FLUSH},   32'd1);
        check_val("exc_trap_lo", {31'b0, bus_if.TRAP_EN}, 32'd0);
        step();
        check_idle("exc_done");
        check_val("exc_code_hold", bus_if.TRAP_CODE, 32'd2);

        // vectored timer interrupt
        bus_if.TRAP_VEC_MODE = 2'd1;
        bus_if.TRAP_VEC_BASE = 32'h1000;
        bus_if.INT_PC        = 32'h300;
        bus_if.INT_ALLOW     = 1'b1;
        bus_if.INT_TIMER     = 1'b1;
        step();
        bus_if.INT_ALLOW = 1'b0;
        clear_reqs();
        check_val("tmr_trap_en", {31'b0, bus_if.TRAP_EN}, 32'd1);
        check_val("tmr_code",    bus_if.TRAP_CODE, 32'h8000_0007);
        check_val("tmr_pc",      bus_if.TRAP_PC,   32'h300);
        step();
        check_val("tmr_jmp_pc",  bus_if.JMP_PC, EXP_TIMER_VEC);
        step();

        // all three interrupts: external wins, vectored offset 0x2C
        bus_if.TRAP_VEC_BASE = 32'h2000;
        bus_if.INT_ALLOW     = 1'b1;
        bus_if.INT_EXT       = 1'b1;
        bus_if.INT_SOFT      = 1'b1;
        bus_if.INT_TIMER     = 1'b1;
        step();
        bus_if.INT_ALLOW = 1'b0;
        clear_reqs();
        check_val("ext_code",   bus_if.TRAP_CODE, 32'h8000_000B);
        step();
        check_val("ext_jmp_pc", bus_if.JMP_PC, EXP_EXT_VEC);
        step();

        // mode 1 exception is never vectored
        bus_if.EXC_EN   = 1'b1;
        bus_if.EXC_CODE = 32'd11;
        bus_if.EXC_PC   = 32'h180;
        step();
        clear_reqs();
        step();
        check_val("m1exc_jmp_pc", bus_if.JMP_PC, 32'h2000);
        step();

        // priority: exception beats mret and external interrupt
        bus_if.TRAP_VEC_MODE = 2'd0;
        bus_if.TRAP_VEC_BASE = 32'h800;
        bus_if.INT_ALLOW     = 1'b1;
        bus_if.EXC_EN        = 1'b1;
        bus_if.EXC_CODE      = 32'd5;
        bus_if.EXC_PC        = 32'h40;
        bus_if.MRET_EN       = 1'b1;
        bus_if.MRET_EPC      = 32'h999;
        bus_if.INT_EXT       = 1'b1;
        step();
        bus_if.EXC_EN    = 1'b0;
        bus_if.MRET_EN   = 1'b0;
        bus_if.INT_ALLOW = 1'b0;
        check_val("pri_trap_en", {31'b0, bus_if.TRAP_EN},     32'd1);
        check_val("pri_code",    bus_if.TRAP_CODE,            32'd5);
        check_val("pri_mret",    {31'b0, bus_if.MRET_COMMIT}, 32'd0);
        step();
        check_val("pri_jmp_pc",  bus_if.JMP_PC, 32'h800);
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle("pri_masked");
        end
        clear_reqs();

        // mret
        bus_if.MRET_EN  = 1'b1;
        bus_if.MRET_EPC = 32'h204;
        step();
        clear_reqs();
        check_val("mret_commit",  {31'b0, bus_if.MRET_COMMIT}, 32'd1);
        check_val("mret_trap_en", {31'b0, bus_if.TRAP_EN},     32'd0);
        check_val("mret_flush",   {31'b0, bus_if.FLUSH},       32'd1);
        check_val("mret_code",    bus_if.TRAP_CODE,            32'd5);
        step();
        check_val("mret_jmp_do",  {31'b0, bus_if.JMP_DO},      32'd1);
        check_val("mret_jmp_pc",  bus_if.JMP_PC,               32'h204);
        check_val("mret_pulse",   {31'b0, bus_if.MRET_COMMIT}, 32'd0);
        step();
        check_idle("mret_done");

        // stall: MMU_WAIT high for 3 cycles after the latch
        bus_if.MMU_WAIT = 1'b1;
        bus_if.EXC_EN   = 1'b1;
        bus_if.EXC_CODE = 32'd7;
        bus_if.EXC_PC   = 32'h500;
        for (int i = 0; i < 3; i++) begin
            step();
            clear_reqs();
            check_val("stall_busy",  {31'b0, bus_if.BUSY},    32'd1);
            check_val("stall_flush", {31'b0, bus_if.FLUSH},   32'd0);
            check_val("stall_trap",  {31'b0, bus_if.TRAP_EN}, 32'd0);
            if (i == 2) bus_if.MMU_WAIT = 1'b0;
        end
        step();
        check_val("stall_trap_en", {31'b0, bus_if.TRAP_EN}, 32'd1);
        check_val("stall_code",    bus_if.TRAP_CODE, 32'd7);
        check_val("stall_pc",      bus_if.TRAP_PC,   32'h500);
        step();
        check_val("stall_jmp_do",  {31'b0, bus_if.JMP_DO}, 32'd1);
        step();

        // back-to-back: held exception gives TRAP_EN every third cycle
        bus_if.EXC_EN   = 1'b1;
        bus_if.EXC_CODE = 32'd3;
        bus_if.EXC_PC   = 32'h600;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("b2b_trap_en", {31'b0, bus_if.TRAP_EN}, (i % 3 == 0) ? 32'd1 : 32'd0);
        end
        clear_reqs();
        step();
        check_idle("b2b_done");

        // reset during COMMIT aborts the sequence
        bus_if.EXC_EN   = 1'b1;
        bus_if.EXC_CODE = 32'd4;
        bus_if.EXC_PC   = 32'h700;
        step();
        clear_reqs();
        check_val("rstc_trap_en", {31'b0, bus_if.TRAP_EN}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("rstc_async");
        check_val("rstc_code",  bus_if.TRAP_CODE, 32'h0);
        check_val("rstc_jmppc", bus_if.JMP_PC,    32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("rstc_after");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
